// File: rtl/spi_rx_fifo_buffer_if.sv
// Receive-side valid/ready handshake between the SPI receive buffer and its consumer.
interface spi_rx_fifo_buffer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] RxData;
  logic             RxValid;
  logic             RxReady;

  modport master (output RxData, output RxValid, input RxReady);
  modport slave  (input RxData, input RxValid, output RxReady);
endinterface

// File: rtl/spi_rx_fifo_buffer.sv
// SPI mode-0 slave receiver: oversampled pins, WIDTH-bit deserialiser, DEPTH-entry registered-output FIFO.
// Optional transmit path enabled by defining SPI_TX_EN.
module spi_rx_fifo_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     IsInitialized,
  input  logic                     SCK,
  input  logic                     CS,
  input  logic                     DI,
  output logic                     DO,
  spi_rx_fifo_buffer_if.master     rx,
  output logic                     Changed,
  output logic                     Overflow,
  input  logic                     OverflowClr,
  output logic [$clog2(DEPTH):0]   Level,
  input  logic [WIDTH-1:0]         TxData,
  output logic                     TxAck
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [SYNC-1:0]  sck_sync_q, sck_sync_d;
  logic [SYNC-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC-1:0]  di_sync_q, di_sync_d;
  logic             sck_prev_q, sck_prev_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             changed_q, changed_d;
  logic             overflow_q, overflow_d;

  logic             sck_s, cs_s, di_s;
  logic             sck_rise, rx_active;
  logic [WIDTH-1:0] word;
  logic             push, pop, full, push_acc, drop;

  assign sck_s     = sck_sync_q[SYNC-1];
  assign cs_s      = cs_sync_q[SYNC-1];
  assign di_s      = di_sync_q[SYNC-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign rx_active = IsInitialized & ~cs_s;
  assign word      = {shift_q[WIDTH-2:0], di_s};

  // Deserialiser: word completes on the WIDTH-th SCK rise and is pushed on that same edge
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC-2:0], SCK};
    cs_sync_d  = {cs_sync_q[SYNC-2:0], CS};
    di_sync_d  = {di_sync_q[SYNC-2:0], DI};
    sck_prev_d = sck_s;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    if (!rx_active) begin
      bit_cnt_d = '0;
      shift_d   = '1;
    end else if (sck_rise) begin
      shift_d = word;
      if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
        push      = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // FIFO; the output register reloads from the head one cycle after occupancy changes
  always_comb begin
    pop        = rx_valid_q & rx.RxReady;
    full       = (level_q == LVL_W'(DEPTH));
    push_acc   = push & (~full | pop);
    drop       = push & full & ~pop;
    mem_d      = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = word;
    end
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + LVL_W'(push_acc) - LVL_W'(pop);
    rx_valid_d = ((level_q - LVL_W'(pop)) != '0);
    rx_data_d  = rx_valid_d ? mem_q[rd_ptr_d] : rx_data_q;
    changed_d  = push;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (OverflowClr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      di_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      changed_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      di_sync_q  <= di_sync_d;
      sck_prev_q <= sck_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      changed_q  <= changed_d;
      overflow_q <= overflow_d;
    end
  end

  assign rx.RxData  = rx_data_q;
  assign rx.RxValid = rx_valid_q;
  assign Changed    = changed_q;
  assign Overflow   = overflow_q;
  assign Level      = level_q;

`ifdef SPI_TX_EN
  logic             cs_prev_q, cs_prev_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             tx_ack_q, tx_ack_d;
  logic             tx_hold_q, tx_hold_d;
  logic             sck_fall, cs_fall;

  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // A reload at word completion already presents the new MSB, so the next SCK fall must not shift it out
  always_comb begin
    cs_prev_d = cs_s;
    tx_d      = tx_q;
    tx_ack_d  = 1'b0;
    tx_hold_d = tx_hold_q;
    if (cs_s) begin
      tx_d      = '1;
      tx_hold_d = 1'b0;
    end else if (cs_fall) begin
      tx_d      = TxData;
      tx_ack_d  = 1'b1;
      tx_hold_d = 1'b0;
    end else if (push) begin
      tx_d      = TxData;
      tx_ack_d  = 1'b1;
      tx_hold_d = 1'b1;
    end else if (sck_fall) begin
      if (tx_hold_q) begin
        tx_hold_d = 1'b0;
      end else begin
        tx_d = {tx_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cs_prev_q <= 1'b1;
      tx_q      <= '1;
      tx_ack_q  <= 1'b0;
      tx_hold_q <= 1'b0;
    end else begin
      cs_prev_q <= cs_prev_d;
      tx_q      <= tx_d;
      tx_ack_q  <= tx_ack_d;
      tx_hold_q <= tx_hold_d;
    end
  end

  assign DO    = tx_q[WIDTH-1];
  assign TxAck = tx_ack_q;
`else
  logic unused_tx_data;
  assign unused_tx_data = ^TxData;
  assign DO    = 1'b1;
  assign TxAck = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_fifo_buffer.sv
// Scoreboard bench for spi_rx_fifo_buffer: expected words queued at send time, compared on each pop.
module tb_spi_rx_fifo_buffer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned HALF  = 4;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             IsInitialized = 1'b0;
  logic             SCK = 1'b0;
  logic             CS = 1'b1;
  logic             DI = 1'b1;
  logic             DO;
  logic             Changed;
  logic             Overflow;
  logic             OverflowClr = 1'b0;
  logic [$clog2(DEPTH):0] Level;
  logic [WIDTH-1:0] TxData = '0;
  logic             TxAck;

  spi_rx_fifo_buffer_if #(.WIDTH(WIDTH)) rx_if ();

  spi_rx_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .CLK(CLK), .reset(reset), .IsInitialized(IsInitialized),
    .SCK(SCK), .CS(CS), .DI(DI), .DO(DO), .rx(rx_if),
    .Changed(Changed), .Overflow(Overflow), .OverflowClr(OverflowClr),
    .Level(Level), .TxData(TxData), .TxAck(TxAck)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int changed_cnt = 0;
  int ack_cnt = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] do_bits = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge
  always @(negedge CLK) begin
    if (!reset) begin
      if (Changed) changed_cnt++;
      if (TxAck) ack_cnt++;
      if (rx_if.RxValid && rx_if.RxReady) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected_pop", 32'(rx_if.RxData), 32'hFFFF_FFFF);
        else check_eq("sb_rx_data", 32'(rx_if.RxData), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic spi_bit(input logic b, input logic pop_at_push);
    DI = b;
    tick(HALF);
    do_bits = {do_bits[WIDTH-2:0], DO};
    SCK = 1'b1;
    tick(SYNC);
    if (pop_at_push) rx_if.RxReady = 1'b1;
    tick(1);
    rx_if.RxReady = 1'b0;
    tick(HALF - SYNC - 1);
    SCK = 1'b0;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input logic pop_last);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(w[i], pop_last && (i == 0));
    tick(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_if.RxReady = 1'b1;
    while ((Level != 0) && (n < 40)) begin
      tick(1);
      n++;
    end
    rx_if.RxReady = 1'b0;
    tick(1);
    check_eq("drain_level", 32'(Level), 32'd0);
    check_eq("drain_valid", 32'(rx_if.RxValid), 32'd0);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(rx_if.RxValid), 32'd0);
    check_eq({tag, "_data"}, 32'(rx_if.RxData), 32'd0);
    check_eq({tag, "_changed"}, 32'(Changed), 32'd0);
    check_eq({tag, "_ovf"}, 32'(Overflow), 32'd0);
    check_eq({tag, "_level"}, 32'(Level), 32'd0);
    check_eq({tag, "_do"}, 32'(DO), 32'd1);
    check_eq({tag, "_txack"}, 32'(TxAck), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rx_if.RxReady = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    IsInitialized = 1'b1;
    CS = 1'b0;
    tick(6);

    // Single word into an empty FIFO
    changed_cnt = 0;
    send_bits(8'hA5, 8, 1'b0);
    exp_q.push_back(8'hA5);
    check_eq("t1_changed", 32'(changed_cnt), 32'd1);
    check_eq("t1_valid", 32'(rx_if.RxValid), 32'd1);
    check_eq("t1_data", 32'(rx_if.RxData), 32'hA5);
    check_eq("t1_level", 32'(Level), 32'd1);
    drain();

    // Overflow: five words into four entries with no reads
    changed_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      send_bits(8'(k), 8, 1'b0);
      if (k <= 4) exp_q.push_back(8'(k));
    end
    check_eq("t2_changed", 32'(changed_cnt), 32'd5);
    check_eq("t2_level", 32'(Level), 32'd4);
    check_eq("t2_ovf", 32'(Overflow), 32'd1);
    check_eq("t2_head_hold", 32'(rx_if.RxData), 32'h01);
    drain();
    check_eq("t2_ovf_sticky", 32'(Overflow), 32'd1);
    OverflowClr = 1'b1;
    tick(1);
    OverflowClr = 1'b0;
    check_eq("t2_ovf_clr", 32'(Overflow), 32'd0);

    // Partial word discarded by CS high
    changed_cnt = 0;
    send_bits(8'h1F, 5, 1'b0);
    CS = 1'b1;
    tick(6);
    CS = 1'b0;
    tick(6);
    send_bits(8'h3C, 8, 1'b0);
    exp_q.push_back(8'h3C);
    check_eq("t3_changed", 32'(changed_cnt), 32'd1);
    check_eq("t3_level", 32'(Level), 32'd1);
    check_eq("t3_data", 32'(rx_if.RxData), 32'h3C);
    drain();

    // Push while full with a simultaneous pop is accepted
    for (int k = 0; k < 4; k++) begin
      send_bits(8'h10 + 8'(k), 8, 1'b0);
      exp_q.push_back(8'h10 + 8'(k));
    end
    check_eq("t4_full", 32'(Level), 32'd4);
    exp_q.push_back(8'h77);
    send_bits(8'h77, 8, 1'b1);
    check_eq("t4_no_ovf", 32'(Overflow), 32'd0);
    check_eq("t4_level", 32'(Level), 32'd4);
    check_eq("t4_head", 32'(rx_if.RxData), 32'h11);
    drain();

    // Receiver disabled, then reset mid-word
    changed_cnt = 0;
    IsInitialized = 1'b0;
    send_bits(8'hFF, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    check_eq("t5_nopush", 32'(changed_cnt), 32'd0);
    check_eq("t5_level", 32'(Level), 32'd0);
    IsInitialized = 1'b1;
    for (int k = 0; k < 5; k++) send_bits(8'h5A, 8, 1'b0);
    check_eq("t5_pre_ovf", 32'(Overflow), 32'd1);
    send_bits(8'hE0, 4, 1'b0);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("t5_rst");
    tick(1);
    reset = 1'b0;
    tick(6);
    send_bits(8'h96, 8, 1'b0);
    exp_q.push_back(8'h96);
    check_eq("t5_after_rst", 32'(rx_if.RxData), 32'h96);
    drain();

`ifdef SPI_TX_EN
    // Transmit: load at CS fall and again at word completion
    CS = 1'b1;
    tick(6);
    TxData = 8'hC3;
    ack_cnt = 0;
    CS = 1'b0;
    tick(6);
    check_eq("t6_ack_csfall", 32'(ack_cnt), 32'd1);
    TxData = 8'h81;
    send_bits(8'h5A, 8, 1'b0);
    exp_q.push_back(8'h5A);
    check_eq("t6_do_bits", 32'(do_bits), 32'hC3);
    check_eq("t6_ack_word", 32'(ack_cnt), 32'd2);
    tick(HALF);
    check_eq("t6_next_msb", 32'(DO), 32'd1);
    drain();
    CS = 1'b1;
    tick(6);
    check_eq("t6_do_idle", 32'(DO), 32'd1);
`else
    ack_cnt = 0;
    send_bits(8'h5A, 8, 1'b0);
    exp_q.push_back(8'h5A);
    check_eq("t6_do_tied", 32'(do_bits), 32'hFF);
    check_eq("t6_no_ack", 32'(ack_cnt), 32'd0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
